garbage_scheduler: RTL and testbench
====================================

# garbage_scheduler

Battle-mode garbage scheduler between the network link and the playfield datapath. It queues incoming garbage attacks from the opponent and uses local line clears to cancel pending garbage. Uncancelled clear lines are forwarded as outgoing attacks. After each no-clear piece lock, it sequences insertion of pending garbage rows into the playfield through a request/done handshake. It is active only while the screen FSM is in MP_MODE.

## Interface
Parameters:
- QUEUE_DEPTH, 8: number of garbage entries held (power of two).
- MAX_INSERT, 8: maximum garbage rows inserted per piece lock.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high; one clock domain.
- mp_active  in  1  high while current_screen == MP_MODE; a low level flushes the block.
- garbage_in_valid  in  1  opponent attack available.
- garbage_in_lines  in  5  attack size, legal 0..20.
- garbage_in_hole  in  4  hole column, 0..9.
- garbage_in_ready  out  1  attack accepted this cycle when valid.
- lines_sent_valid  in  1  one-cycle pulse at piece lock carrying local attack value.
- lines_sent  in  5  attack lines generated by the local clear, 0..20.
- piece_lock  in  1  one-cycle falling_piece_lock pulse.
- insert_req  out  1  request playfield to shift up and insert rows.
- insert_lines  out  5  rows to insert, 1..MAX_INSERT.
- insert_hole  out  4  hole column of inserted rows.
- insert_done  in  1  playfield completed the insertion (single pulse).
- attack_valid  out  1  outgoing attack pending.
- attack_lines  out  5  outgoing attack size.
- attack_ready  in  1  network link accepts attack.
- pending_total  out  8  sum of queued garbage lines (meter display).

## Operation
- Queue: circular FIFO of {lines[4:0], hole[3:0]} entries. The head entry's lines field is writable in place.
- garbage_in_ready = ~full | ~mp_active.
  - On accept with mp_active=1 and lines != 0: push the entry.
  - On accept with lines == 0, or with mp_active=0: discard.
- sent_pending (5b) collects lines_sent with a saturating add at 31 whenever lines_sent_valid=1, in any state.
- lock_pending (1b) is set by piece_lock when lines_sent_valid=0 or lines_sent=0 in the same cycle. A lock that arrives with a clear never triggers insertion. A second lock while the flag is already set is absorbed.
- Everything below applies only while mp_active=1.
- States: IDLE, CANCEL, INSERT, STEP.
- IDLE: priority order:
  - sent_pending != 0 (including a same-cycle arrival) → CANCEL.
  - Else lock_pending and queue non-empty → INSERT, with budget = MAX_INSERT.
  - Else lock_pending and queue empty → clear lock_pending.
- CANCEL: one head entry per cycle; c = min(sent_pending, head.lines).
  - head.lines -= c and sent_pending -= c; pop the head if it reaches 0.
  - Return to IDLE when sent_pending reaches 0.
  - If the queue is empty: add sent_pending to attack_lines (saturating at 31), set attack_valid, clear sent_pending, go to IDLE.
- INSERT: hold insert_req=1, insert_lines = min(head.lines, budget), insert_hole = head.hole.
  - The outputs stay stable until insert_done.
  - On insert_done: deassert insert_req, subtract k from head.lines and from budget, pop the head if 0, go to STEP.
- STEP: if budget == 0 or the queue is empty, clear lock_pending and go to IDLE; else go to INSERT.
- pending_total is updated on every push, cancel and insert. Invariant: pending_total equals the sum of queued lines.
- Attack handshake: attack_valid & attack_ready clears attack_lines and attack_valid. A same-cycle addition becomes the new value, with attack_valid staying 1.
- Flush when mp_active=0, checked every cycle with priority over all other logic: queue empty, pending_total=0, sent_pending=0, lock_pending=0, attack_valid=0, attack_lines=0, insert_req=0, state=IDLE.

## Timing
- Reset values: state IDLE, queue empty, insert_req=0, insert_lines=0, insert_hole=0, attack_valid=0, attack_lines=0, pending_total=0.
- garbage_in_ready is combinational and reads 1 after reset.
- A push at cycle t is reflected in pending_total at t+1.
- A lock at t with IDLE, queue non-empty and no clear gives insert_req=1 at t+1.
  - insert_done at t+n drops insert_req at t+n+1.
  - The next entry's insert_req rises at t+n+2, giving a one-cycle gap.
- lines_sent at t in IDLE: CANCEL runs at t+1; each queue entry costs one cycle.
  - attack_valid rises the cycle after the CANCEL cycle that finds the queue empty.
- Full queue: garbage_in_ready=0 and upstream holds its data; nothing is dropped.
- The queue is never popped and pushed into the same slot in the same cycle; a simultaneous push and pop must both take effect.
- insert_done outside INSERT is ignored.

## Test plan
- Push 3@col2 then 4@col7, then a no-clear lock → insert_req (3,2), done, one-cycle gap, insert_req (4,7), done; pending_total goes 7→4→0.
- Queue {3,4}, then lines_sent=5 at a lock → head popped, second entry reduced to 2, no insertion, attack_valid stays 0, pending_total=2.
- Empty queue, lines_sent=4 → attack_valid=1 and attack_lines=4. Hold attack_ready=0 and pulse lines_sent=30 → attack_lines saturates at 31.
- Single entry 12@col0 with MAX_INSERT=8 and a no-clear lock → one insert_req with 8 rows. A head of 4 remains until the next lock, which inserts 4.
- Fill 8 entries → garbage_in_ready=0; a 9th valid is held until a pop, then accepted.
- Drop mp_active mid-INSERT → next cycle insert_req=0, pending_total=0, and further garbage_in_valid is accepted and discarded.

Source files
------------

// File: rtl/garbage_scheduler.sv
// Battle-mode garbage scheduler: queues opponent attacks, cancels them with local
// clears, forwards the surplus as outgoing attacks and sequences row insertion.
module garbage_scheduler #(
   parameter int unsigned QUEUE_DEPTH = 8,
   parameter int unsigned MAX_INSERT  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mp_active,
   input  logic       garbage_in_valid,
   input  logic [4:0] garbage_in_lines,
   input  logic [3:0] garbage_in_hole,
   output logic       garbage_in_ready,
   input  logic       lines_sent_valid,
   input  logic [4:0] lines_sent,
   input  logic       piece_lock,
   output logic       insert_req,
   output logic [4:0] insert_lines,
   output logic [3:0] insert_hole,
   input  logic       insert_done,
   output logic       attack_valid,
   output logic [4:0] attack_lines,
   input  logic       attack_ready,
   output logic [7:0] pending_total
);
   localparam int unsigned LINE_W = 5;
   localparam int unsigned HOLE_W = 4;
   localparam int unsigned TOT_W  = 8;
   localparam int unsigned PTR_W  = $clog2(QUEUE_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam logic [LINE_W-1:0] LINE_MAX    = '1;
   localparam logic [LINE_W-1:0] BUDGET_INIT = LINE_W'(MAX_INSERT);
   localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(QUEUE_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_CANCEL, S_INSERT, S_STEP} state_t;

   function automatic logic [LINE_W-1:0] sat_add(input logic [LINE_W-1:0] a,
                                                 input logic [LINE_W-1:0] b);
      logic [LINE_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[LINE_W] ? LINE_MAX : s[LINE_W-1:0];
   endfunction

   function automatic logic [LINE_W-1:0] min_l(input logic [LINE_W-1:0] a,
                                               input logic [LINE_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [LINE_W-1:0]  sent_pending_q, sent_pending_d;
   logic               lock_pending_q, lock_pending_d;
   logic [LINE_W-1:0]  budget_q, budget_d;
   logic               insert_req_q, insert_req_d;
   logic [LINE_W-1:0]  insert_lines_q, insert_lines_d;
   logic [HOLE_W-1:0]  insert_hole_q, insert_hole_d;
   logic               attack_valid_q, attack_valid_d;
   logic [LINE_W-1:0]  attack_lines_q, attack_lines_d;
   logic [TOT_W-1:0]   pending_total_q, pending_total_d;

   logic [LINE_W-1:0]  mem_lines [QUEUE_DEPTH];
   logic [HOLE_W-1:0]  mem_hole  [QUEUE_DEPTH];

   logic               full, empty, push_en, pop_en, head_we, lock_set;
   logic [LINE_W-1:0]  head_lines, head_new, dec_amt, attack_add;
   logic [LINE_W-1:0]  sent_in, sent_eff, cancel_amt;
   logic [HOLE_W-1:0]  head_hole;

   assign full       = (count_q == DEPTH_C);
   assign empty      = (count_q == '0);
   assign head_lines = mem_lines[rd_ptr_q];
   assign head_hole  = mem_hole[rd_ptr_q];

   assign garbage_in_ready = ~full | ~mp_active;
   assign insert_req       = insert_req_q;
   assign insert_lines     = insert_lines_q;
   assign insert_hole      = insert_hole_q;
   assign attack_valid     = attack_valid_q;
   assign attack_lines     = attack_lines_q;
   assign pending_total    = pending_total_q;

   // Next-state, queue updates and outputs; flush overrides everything last
   always_comb begin
      state_d         = state_q;
      rd_ptr_d        = rd_ptr_q;
      wr_ptr_d        = wr_ptr_q;
      count_d         = count_q;
      budget_d        = budget_q;
      insert_req_d    = insert_req_q;
      insert_lines_d  = insert_lines_q;
      insert_hole_d   = insert_hole_q;
      attack_valid_d  = attack_valid_q;
      attack_lines_d  = attack_lines_q;
      pending_total_d = pending_total_q;
      pop_en          = 1'b0;
      head_we         = 1'b0;
      dec_amt         = '0;
      attack_add      = '0;
      cancel_amt      = '0;
      head_new        = head_lines;

      sent_in        = lines_sent_valid ? lines_sent : '0;
      sent_eff       = sat_add(sent_pending_q, sent_in);
      sent_pending_d = sent_eff;
      lock_set       = piece_lock & ~(lines_sent_valid & (lines_sent != '0));
      lock_pending_d = lock_pending_q | lock_set;
      push_en        = garbage_in_valid & mp_active & ~full & (garbage_in_lines != '0);

      case (state_q)
         S_IDLE: begin
            if (sent_eff != '0) begin
               state_d = S_CANCEL;
            end else if (lock_pending_d) begin
               if (!empty) begin
                  state_d        = S_INSERT;
                  budget_d       = BUDGET_INIT;
                  insert_req_d   = 1'b1;
                  insert_lines_d = min_l(head_lines, BUDGET_INIT);
                  insert_hole_d  = head_hole;
               end else begin
                  lock_pending_d = 1'b0;
               end
            end
         end
         S_CANCEL: begin
            if (empty) begin
               attack_add     = sent_pending_q;
               sent_pending_d = sent_in;
               state_d        = S_IDLE;
            end else begin
               cancel_amt     = min_l(sent_pending_q, head_lines);
               dec_amt        = cancel_amt;
               head_we        = 1'b1;
               head_new       = head_lines - cancel_amt;
               pop_en         = (head_new == '0);
               sent_pending_d = sat_add(sent_pending_q - cancel_amt, sent_in);
               if (sent_pending_q == cancel_amt) state_d = S_IDLE;
            end
         end
         S_INSERT: begin
            if (insert_done) begin
               dec_amt      = insert_lines_q;
               head_we      = 1'b1;
               head_new     = head_lines - insert_lines_q;
               pop_en       = (head_new == '0);
               budget_d     = budget_q - insert_lines_q;
               insert_req_d = 1'b0;
               state_d      = S_STEP;
            end
         end
         S_STEP: begin
            if ((budget_q == '0) || empty) begin
               lock_pending_d = 1'b0;
               state_d        = S_IDLE;
            end else begin
               state_d        = S_INSERT;
               insert_req_d   = 1'b1;
               insert_lines_d = min_l(head_lines, budget_q);
               insert_hole_d  = head_hole;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Accepted attack is replaced by any same-cycle addition
      if (attack_valid_q && attack_ready) begin
         attack_lines_d = attack_add;
         attack_valid_d = (attack_add != '0);
      end else begin
         attack_lines_d = sat_add(attack_lines_q, attack_add);
         attack_valid_d = attack_valid_q | (attack_add != '0);
      end

      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
      pending_total_d = pending_total_q
                      + (push_en ? TOT_W'(garbage_in_lines) : TOT_W'(0))
                      - TOT_W'(dec_amt);

      if (!mp_active) begin
         state_d         = S_IDLE;
         rd_ptr_d        = '0;
         wr_ptr_d        = '0;
         count_d         = '0;
         sent_pending_d  = '0;
         lock_pending_d  = 1'b0;
         budget_d        = '0;
         insert_req_d    = 1'b0;
         insert_lines_d  = '0;
         insert_hole_d   = '0;
         attack_valid_d  = 1'b0;
         attack_lines_d  = '0;
         pending_total_d = '0;
         push_en         = 1'b0;
         pop_en          = 1'b0;
         head_we         = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         rd_ptr_q        <= '0;
         wr_ptr_q        <= '0;
         count_q         <= '0;
         sent_pending_q  <= '0;
         lock_pending_q  <= 1'b0;
         budget_q        <= '0;
         insert_req_q    <= 1'b0;
         insert_lines_q  <= '0;
         insert_hole_q   <= '0;
         attack_valid_q  <= 1'b0;
         attack_lines_q  <= '0;
         pending_total_q <= '0;
      end else begin
         state_q         <= state_d;
         rd_ptr_q        <= rd_ptr_d;
         wr_ptr_q        <= wr_ptr_d;
         count_q         <= count_d;
         sent_pending_q  <= sent_pending_d;
         lock_pending_q  <= lock_pending_d;
         budget_q        <= budget_d;
         insert_req_q    <= insert_req_d;
         insert_lines_q  <= insert_lines_d;
         insert_hole_q   <= insert_hole_d;
         attack_valid_q  <= attack_valid_d;
         attack_lines_q  <= attack_lines_d;
         pending_total_q <= pending_total_d;
      end
   end

   // Push slot and head slot never coincide: push needs ~full, head write needs ~empty
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_lines[wr_ptr_q] <= garbage_in_lines;
         mem_hole[wr_ptr_q]  <= garbage_in_hole;
      end
      if (head_we) mem_lines[rd_ptr_q] <= head_new;
   end
endmodule

// File: tb/tb_garbage_scheduler.sv
// Self-checking bench for garbage_scheduler: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_garbage_scheduler;
   localparam int DEPTH = 8;
   localparam int MAXI  = 8;

   logic       clk = 1'b0;
   logic       rst, mp_active;
   logic       garbage_in_valid;
   logic [4:0] garbage_in_lines;
   logic [3:0] garbage_in_hole;
   logic       garbage_in_ready;
   logic       lines_sent_valid;
   logic [4:0] lines_sent;
   logic       piece_lock;
   logic       insert_req;
   logic [4:0] insert_lines;
   logic [3:0] insert_hole;
   logic       insert_done;
   logic       attack_valid;
   logic [4:0] attack_lines;
   logic       attack_ready;
   logic [7:0] pending_total;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   garbage_scheduler #(.QUEUE_DEPTH(DEPTH), .MAX_INSERT(MAXI)) dut (
      .clk(clk), .rst(rst), .mp_active(mp_active),
      .garbage_in_valid(garbage_in_valid), .garbage_in_lines(garbage_in_lines),
      .garbage_in_hole(garbage_in_hole), .garbage_in_ready(garbage_in_ready),
      .lines_sent_valid(lines_sent_valid), .lines_sent(lines_sent),
      .piece_lock(piece_lock), .insert_req(insert_req), .insert_lines(insert_lines),
      .insert_hole(insert_hole), .insert_done(insert_done),
      .attack_valid(attack_valid), .attack_lines(attack_lines),
      .attack_ready(attack_ready), .pending_total(pending_total)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int q_lines[$];
   int q_hole[$];
   int m_mode, m_sent, m_lock, m_budget, m_ireq, m_il, m_ih, m_av, m_al;
   int t_sin, t_add, t_c, t_new;
   bit t_lset, t_push;

   function automatic int sat31(input int v);
      return (v > 31) ? 31 : v;
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int qsum();
      int s;
      s = 0;
      foreach (q_lines[i]) s += q_lines[i];
      return s;
   endfunction

   task automatic model_clear();
      q_lines.delete();
      q_hole.delete();
      m_mode = 0; m_sent = 0; m_lock = 0; m_budget = 0;
      m_ireq = 0; m_il = 0; m_ih = 0; m_av = 0; m_al = 0;
   endtask

   task automatic model_pop_if_zero();
      if (q_lines[0] == 0) begin
         void'(q_lines.pop_front());
         void'(q_hole.pop_front());
      end
   endtask

   // mode: 0 waiting, 1 cancelling, 2 insertion requested, 3 between insertions
   always @(posedge clk) begin
      if (rst || !mp_active) begin
         model_clear();
      end else begin
         t_sin  = lines_sent_valid ? int'(lines_sent) : 0;
         t_lset = piece_lock && !(lines_sent_valid && (lines_sent != 5'd0));
         t_push = garbage_in_valid && (q_lines.size() < DEPTH) && (garbage_in_lines != 5'd0);
         t_add  = 0;
         t_new  = sat31(m_sent + t_sin);
         if (t_lset) m_lock = 1;
         case (m_mode)
            0: begin
               if (t_new != 0) m_mode = 1;
               else if (m_lock != 0) begin
                  if (q_lines.size() != 0) begin
                     m_mode = 2; m_budget = MAXI; m_ireq = 1;
                     m_il = imin(q_lines[0], MAXI); m_ih = q_hole[0];
                  end else m_lock = 0;
               end
            end
            1: begin
               if (q_lines.size() == 0) begin
                  t_add = m_sent; t_new = t_sin; m_mode = 0;
               end else begin
                  t_c = imin(m_sent, q_lines[0]);
                  q_lines[0] -= t_c;
                  model_pop_if_zero();
                  t_new = sat31(m_sent - t_c + t_sin);
                  if (m_sent == t_c) m_mode = 0;
               end
            end
            2: begin
               if (insert_done) begin
                  q_lines[0] -= m_il;
                  m_budget -= m_il;
                  model_pop_if_zero();
                  m_ireq = 0; m_mode = 3;
               end
            end
            default: begin
               if (m_budget == 0 || q_lines.size() == 0) begin
                  m_lock = 0; m_mode = 0;
               end else begin
                  m_mode = 2; m_ireq = 1;
                  m_il = imin(q_lines[0], m_budget); m_ih = q_hole[0];
               end
            end
         endcase
         m_sent = t_new;
         if (m_av != 0 && attack_ready) begin
            m_al = t_add; m_av = (t_add != 0) ? 1 : 0;
         end else if (t_add != 0) begin
            m_al = sat31(m_al + t_add); m_av = 1;
         end
         if (t_push) begin
            q_lines.push_back(int'(garbage_in_lines));
            q_hole.push_back(int'(garbage_in_hole));
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("ready", int'(garbage_in_ready), (q_lines.size() < DEPTH || !mp_active) ? 1 : 0);
         chk("insert_req", int'(insert_req), m_ireq);
         if (m_ireq != 0) begin
            chk("insert_lines", int'(insert_lines), m_il);
            chk("insert_hole", int'(insert_hole), m_ih);
         end
         chk("attack_valid", int'(attack_valid), m_av);
         chk("attack_lines", int'(attack_lines), m_al);
         chk("pending_total", int'(pending_total), qsum());
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push(input int l, input int h);
      garbage_in_valid = 1'b1;
      garbage_in_lines = 5'(l);
      garbage_in_hole  = 4'(h);
      tick();
      garbage_in_valid = 1'b0;
   endtask

   task automatic lock_pulse();
      piece_lock = 1'b1;
      tick();
      piece_lock = 1'b0;
   endtask

   task automatic sent_pulse(input int n, input bit with_lock);
      lines_sent_valid = 1'b1;
      lines_sent       = 5'(n);
      piece_lock       = with_lock;
      tick();
      lines_sent_valid = 1'b0;
      piece_lock       = 1'b0;
   endtask

   task automatic do_insert(input int l, input int h);
      int n;
      n = 0;
      while (!insert_req && n < 30) begin
         tick();
         n++;
      end
      chk("insert_req_wait", int'(insert_req), 1);
      chk("insert_lines_lit", int'(insert_lines), l);
      chk("insert_hole_lit", int'(insert_hole), h);
      ticks(2);
      insert_done = 1'b1;
      tick();
      insert_done = 1'b0;
      chk("insert_req_drop", int'(insert_req), 0);
   endtask

   initial begin
      rst = 1'b1; mp_active = 1'b1;
      garbage_in_valid = 1'b0; garbage_in_lines = '0; garbage_in_hole = '0;
      lines_sent_valid = 1'b0; lines_sent = '0; piece_lock = 1'b0;
      insert_done = 1'b0; attack_ready = 1'b0;
      ticks(2);
      rst = 1'b0;
      cmp_en = 1'b1;
      chk("rst_insert_req", int'(insert_req), 0);
      chk("rst_insert_lines", int'(insert_lines), 0);
      chk("rst_insert_hole", int'(insert_hole), 0);
      chk("rst_attack_valid", int'(attack_valid), 0);
      chk("rst_attack_lines", int'(attack_lines), 0);
      chk("rst_pending", int'(pending_total), 0);
      chk("rst_ready", int'(garbage_in_ready), 1);

      // two entries inserted after a no-clear lock
      push(3, 2);
      chk("push_pending_3", int'(pending_total), 3);
      push(4, 7);
      chk("push_pending_7", int'(pending_total), 7);
      lock_pulse();
      chk("lock_req_next", int'(insert_req), 1);
      do_insert(3, 2);
      chk("pending_after_3", int'(pending_total), 4);
      chk("gap_cycle", int'(insert_req), 0);
      do_insert(4, 7);
      chk("pending_after_4", int'(pending_total), 0);
      ticks(3);

      // clear at a lock cancels queued garbage and never inserts
      push(3, 1);
      push(4, 5);
      sent_pulse(5, 1'b1);
      ticks(5);
      chk("cancel_pending", int'(pending_total), 2);
      chk("cancel_no_attack", int'(attack_valid), 0);
      chk("cancel_no_insert", int'(insert_req), 0);
      sent_pulse(2, 1'b0);
      ticks(4);
      chk("cancel_drain", int'(pending_total), 0);

      // surplus becomes outgoing attack, saturating at 31
      sent_pulse(4, 1'b0);
      ticks(4);
      chk("atk_valid_4", int'(attack_valid), 1);
      chk("atk_lines_4", int'(attack_lines), 4);
      sent_pulse(30, 1'b0);
      ticks(4);
      chk("atk_sat", int'(attack_lines), 31);
      attack_ready = 1'b1;
      tick();
      attack_ready = 1'b0;
      chk("atk_clear_v", int'(attack_valid), 0);
      chk("atk_clear_l", int'(attack_lines), 0);
      sent_pulse(3, 1'b0);
      ticks(4);
      sent_pulse(6, 1'b0);
      attack_ready = 1'b1;
      tick();
      attack_ready = 1'b0;
      chk("atk_replace_v", int'(attack_valid), 1);
      chk("atk_replace_l", int'(attack_lines), 6);
      attack_ready = 1'b1;
      tick();
      attack_ready = 1'b0;

      // insertion budget limits a large entry
      push(12, 0);
      lock_pulse();
      do_insert(8, 0);
      ticks(3);
      chk("budget_rem", int'(pending_total), 4);
      chk("budget_idle", int'(insert_req), 0);
      lock_pulse();
      do_insert(4, 0);
      ticks(2);
      chk("budget_done", int'(pending_total), 0);

      // full queue backpressure
      for (int i = 0; i < DEPTH; i++) push(i + 1, i);
      chk("full_ready", int'(garbage_in_ready), 0);
      chk("full_pending", int'(pending_total), 36);
      garbage_in_valid = 1'b1; garbage_in_lines = 5'd5; garbage_in_hole = 4'd9;
      ticks(3);
      chk("full_held", int'(pending_total), 36);
      lock_pulse();
      do_insert(1, 0);
      chk("full_freed", int'(garbage_in_ready), 1);
      tick();
      garbage_in_valid = 1'b0;
      do_insert(2, 1);
      do_insert(3, 2);
      do_insert(2, 3);
      ticks(2);
      chk("full_after", int'(pending_total), 33);
      chk("full_after_req", int'(insert_req), 0);

      // flush during insertion
      lock_pulse();
      chk("flush_req_up", int'(insert_req), 1);
      chk("flush_lines", int'(insert_lines), 2);
      mp_active = 1'b0;
      tick();
      chk("flush_req", int'(insert_req), 0);
      chk("flush_pending", int'(pending_total), 0);
      chk("flush_ready", int'(garbage_in_ready), 1);
      push(6, 1);
      chk("flush_discard", int'(pending_total), 0);
      mp_active = 1'b1;
      tick();
      insert_done = 1'b1;
      tick();
      insert_done = 1'b0;
      chk("stray_done", int'(insert_req), 0);
      push(5, 3);
      chk("resume_push", int'(pending_total), 5);
      ticks(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
